// File: rtl/imem_dmem_arbiter_if.sv
// Pipeline-side request/response bundle for the shared memory arbiter.
// The fetch port is read-only; the data port also carries writes.
interface imem_dmem_arbiter_if #(
  parameter int AW = 12
) ();
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_resp_valid;
  logic [31:0]   if_resp_data;
  logic          d_req_valid;
  logic          d_req_ready;
  logic          d_req_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wmask;
  logic          d_resp_valid;
  logic [31:0]   d_resp_data;

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_req_we, d_addr,
    output d_wdata, d_wmask,
    input  if_req_ready, if_resp_valid,
    input  if_resp_data,
    input  d_req_ready, d_resp_valid,
    input  d_resp_data
  );

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_req_we, d_addr,
    input  d_wdata, d_wmask,
    output if_req_ready, if_resp_valid,
    output if_resp_data,
    output d_req_ready, d_resp_valid,
    output d_resp_data
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous memory between fetch and data ports.
// Data wins by default; fetch overrides after MAX_STARVE denied cycles.
module imem_dmem_arbiter #(
  parameter int AW         = 12,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_dmem_arbiter_if.slave bus,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       if_stall_cnt
);

  localparam int SW =
    (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_IF,
    RESP_D
  } resp_e;

  resp_e         state;
  resp_e         state_nxt;
  logic [SW-1:0] starve;
  logic          starve_hit;
  logic          if_win;
  logic          d_win;

  assign starve_hit = (MAX_STARVE > 0)
                   && bus.if_req_valid
                   && (starve == STARVE_MAX);

  // one grant per cycle; nothing granted while reset is held
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        starve_hit:
          if_win = 1'b1;
        bus.d_req_valid && !starve_hit:
          d_win = 1'b1;
        bus.if_req_valid && !bus.d_req_valid:
          if_win = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.if_req_ready = if_win;
  assign bus.d_req_ready  = d_win;

  // drive the memory from whichever port holds the grant
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'b0;
    mem_addr = '0;
    mem_din  = 32'b0;
    if (d_win) begin
      mem_en   = 1'b1;
      mem_addr = bus.d_addr;
      if (bus.d_req_we) begin
        mem_we  = bus.d_wmask;
        mem_din = bus.d_wdata;
      end
    end else if (if_win) begin
      mem_en   = 1'b1;
      mem_addr = bus.if_addr;
    end
  end

  // count consecutive fetch denials, saturating at the override point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (!bus.if_req_valid || if_win) begin
      starve <= '0;
    end else if (starve != STARVE_MAX) begin
      starve <= starve + 1'b1;
    end
  end

  // free-running fetch stall counter for performance monitoring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_cnt <= 32'b0;
    end else if (bus.if_req_valid && !bus.if_req_ready) begin
      if_stall_cnt <= if_stall_cnt + 32'd1;
    end
  end

  // response owner register: who gets mem_dout next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESP_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  // next owner from this cycle's grant; route read data to the owner
  always_comb begin
    state_nxt         = RESP_NONE;
    bus.if_resp_valid = 1'b0;
    bus.if_resp_data  = 32'b0;
    bus.d_resp_valid  = 1'b0;
    bus.d_resp_data   = 32'b0;
    if (if_win) begin
      state_nxt = RESP_IF;
    end else if (d_win && !bus.d_req_we) begin
      state_nxt = RESP_D;
    end
    unique case (state)
      RESP_IF: begin
        bus.if_resp_valid = 1'b1;
        bus.if_resp_data  = mem_dout;
      end
      RESP_D: begin
        bus.d_resp_valid = 1'b1;
        bus.d_resp_data  = mem_dout;
      end
      default: ;
    endcase
  end

endmodule
